// File: rtl/lock_pkg.sv
// Shared types and defaults for the code lock controller.
// Contents: the lock_state_t FSM state type, the default parameter values,
// and a small max helper used for sizing the shared timer.
package lock_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } lock_state_t;

  localparam int DEF_OPEN_CYCLES    = 8;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// Keypad/detector-side bundle for the code lock controller.
// Signals:
//   match_i    - detector final-state level
//   attempt_i  - one-cycle enter strobe
//   relock_i   - early relock request
//   unlock_o   - lock actuator drive
//   alarm_o    - lockout alarm
//   fail_cnt_o - consecutive-failure count, FW bits wide
// Modports:
//   master - keypad/detector side
//   slave  - lock controller side
interface code_lock_ctrl_if #(
  parameter int FW = 2
);
  logic          match_i;
  logic          attempt_i;
  logic          relock_i;
  logic          unlock_o;
  logic          alarm_o;
  logic [FW-1:0] fail_cnt_o;

  modport master (
    output match_i, attempt_i, relock_i,
    input  unlock_o, alarm_o, fail_cnt_o
  );

  modport slave (
    input  match_i, attempt_i, relock_i,
    output unlock_o, alarm_o, fail_cnt_o
  );
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT windows.
// Ports:
//   clk, rst  - clock and synchronous active-low reset
//   load      - load load_val (takes priority over counting)
//   load_val  - value loaded on entry to a timed state
//   en        - decrement enable
//   zero      - counter currently at 0
// Behaviour: the counter stops at 0 and never wraps.
module lock_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/code_lock_ctrl.sv
// Code lock controller: consumes the sequence detector's match level and the
// keypad enter strobe, drives the lock actuator, counts consecutive wrong
// entries and raises a timed lockout alarm when the limit is reached.
//
// Ports:
//   clk, rst  - clock and synchronous active-low reset
//   bus       - code_lock_ctrl_if.slave
//               (match_i, attempt_i, relock_i in;
//                unlock_o, alarm_o, fail_cnt_o out)
//
// state   | meaning
// --------+------------------------------------------------------------
// LOCKED  | idle, waiting for an entry; wrong entries counted
// OPEN    | actuator driven for OPEN_CYCLES or until relock
// LOCKOUT | alarm driven for LOCKOUT_CYCLES; all inputs ignored
module code_lock_ctrl
  import lock_pkg::*;
#(
  parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input logic             clk,
  input logic             rst,
  code_lock_ctrl_if.slave bus
);
  localparam int TW = $clog2(max_int(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW:0]   FAIL_LIMIT = (FW + 1)'(MAX_FAILS);
  localparam logic [FW-1:0] FAIL_SAT   = FW'(MAX_FAILS);

  lock_state_t   state;
  logic [FW-1:0] fail_cnt;
  logic          unlock_q;
  logic          alarm_q;

  logic          accept;
  logic          reject;
  logic          fail_limit;
  logic [FW:0]   fail_inc;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_en;
  logic          tmr_zero;

  // One extra bit on the increment so the limit compare cannot wrap.
  always_comb begin
    fail_inc     = {1'b0, fail_cnt} + (FW + 1)'(1);
    accept       = (state == LOCKED) && bus.attempt_i && bus.match_i;
    reject       = (state == LOCKED) && bus.attempt_i && !bus.match_i;
    fail_limit   = (fail_inc >= FAIL_LIMIT);
    tmr_load     = accept || (reject && fail_limit);
    tmr_load_val = accept ? OPEN_LOAD : LOCK_LOAD;
    tmr_en       = (state == OPEN) || (state == LOCKOUT);
  end

  lock_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Outputs are registered alongside the state, set from the state being
  // entered, so they always equal a decode of the registered state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= LOCKED;
      fail_cnt <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      case (state)
        LOCKED: begin
          unlock_q <= 1'b0;
          alarm_q  <= 1'b0;
          if (accept) begin
            state    <= OPEN;
            fail_cnt <= '0;
            unlock_q <= 1'b1;
          end else if (reject) begin
            if (fail_limit) begin
              state    <= LOCKOUT;
              fail_cnt <= FAIL_SAT;
              alarm_q  <= 1'b1;
            end else begin
              fail_cnt <= fail_inc[FW-1:0];
            end
          end
        end
        OPEN: begin
          fail_cnt <= '0;
          alarm_q  <= 1'b0;
          unlock_q <= 1'b1;
          if (bus.relock_i || tmr_zero) begin
            state    <= LOCKED;
            unlock_q <= 1'b0;
          end
        end
        LOCKOUT: begin
          unlock_q <= 1'b0;
          alarm_q  <= 1'b1;
          if (tmr_zero) begin
            state    <= LOCKED;
            fail_cnt <= '0;
            alarm_q  <= 1'b0;
          end
        end
        default: begin
          state    <= LOCKED;
          fail_cnt <= '0;
          unlock_q <= 1'b0;
          alarm_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unlock_o   = unlock_q;
  assign bus.alarm_o    = alarm_q;
  assign bus.fail_cnt_o = fail_cnt;
endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
Downstream consumer of the 4-digit code-sequence detector. It takes the detector's match level and the user's "enter" strobe and drives the lock actuator. Accepted codes open the lock for a timed window. Consecutive wrong entries are counted, and reaching a limit triggers a timed lockout with alarm. The detector output connects directly to match_i.

Parameters:
OPEN_CYCLES, 8, cycles unlock_o stays high after an accepted entry (>=1)
MAX_FAILS, 3, consecutive rejected entries that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, cycles alarm_o stays high in lockout (>=1)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 sampled at posedge resets the block)
match_i  in  1  detector output; high while the detector sits in its final state
attempt_i  in  1  one-cycle "enter" strobe from the keypad
relock_i  in  1  early relock request (door closed)
unlock_o  out  1  lock actuator drive, registered
alarm_o  out  1  lockout alarm, registered
fail_cnt_o  out  $clog2(MAX_FAILS+1)  current consecutive-failure count

Behaviour:
- Reset (rst==0 at an edge): state LOCKED, timer 0, fail_cnt 0, unlock_o 0, alarm_o 0. Reset wins over every other input, including mid-OPEN and mid-LOCKOUT.
- States are LOCKED, OPEN and LOCKOUT. Outputs are Moore: unlock_o = (state==OPEN) and alarm_o = (state==LOCKOUT), decoded from registered state.
- LOCKED:
  - attempt_i & match_i -> OPEN; timer loads OPEN_CYCLES-1; fail_cnt clears to 0.
  - attempt_i & !match_i with fail_cnt+1 < MAX_FAILS -> stay LOCKED; fail_cnt increments.
  - attempt_i & !match_i with fail_cnt+1 == MAX_FAILS -> LOCKOUT; timer loads LOCKOUT_CYCLES-1; fail_cnt holds at MAX_FAILS.
  - match_i without attempt_i is ignored. relock_i is ignored.
- OPEN:
  - timer decrements each cycle.
  - relock_i==1, or timer==0 -> LOCKED next edge. Both together also -> LOCKED.
  - attempt_i and match_i are ignored; fail_cnt stays 0.
- LOCKOUT:
  - timer decrements each cycle.
  - timer==0 -> LOCKED; fail_cnt clears to 0.
  - All data inputs are ignored, including relock_i and attempt_i & match_i.
- Latency: an accepting/rejecting edge N produces its output change visible after edge N (cycle N+1).
  - unlock_o is high for exactly OPEN_CYCLES cycles unless relocked early.
  - alarm_o is high for exactly LOCKOUT_CYCLES cycles.
- Timer width: $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1), computed as a localparam. The timer never wraps: loads only on entry, stops at 0.
- fail_cnt saturates at MAX_FAILS and never wraps.
- Illegal state encoding -> LOCKED next edge, outputs 0.
- With MAX_FAILS==1, a single rejected entry goes straight to LOCKOUT.

Decomposition:
- Package lock_pkg holds:
  - typedef enum logic[1:0] {LOCKED, OPEN, LOCKOUT} lock_state_t
  - default parameter constants
- One sub-module, lock_timer: loadable down-counter.
  - Inputs: load, load_val, en.
  - Output: zero flag.
  - Same clk/rst convention.
  - Instantiated once and shared by OPEN and LOCKOUT.
- FSM and fail counter live in code_lock_ctrl.

Test Plan:
1. rst=0 for 2 edges with attempt_i=match_i=1 -> unlock_o=0, alarm_o=0, fail_cnt_o=0 throughout and on the first cycle after release.
2. After reset, attempt_i=match_i=1 at edge N -> unlock_o=1 for cycles N+1..N+8, unlock_o=0 at N+9; fail_cnt_o=0.
3. Three attempt_i pulses with match_i=0 -> fail_cnt_o steps 1, 2, then alarm_o=1 for 16 cycles. During lockout, attempt_i=match_i=1 is ignored (unlock_o stays 0). After lockout, fail_cnt_o=0 and state is LOCKED.
4. Open the lock, then assert relock_i in the 3rd OPEN cycle -> unlock_o=0 on the following cycle. A subsequent attempt_i=match_i=1 reopens for a full 8 cycles.
5. Two rejected attempts (fail_cnt_o=2), then attempt_i=match_i=1 -> unlock_o=1 next cycle, fail_cnt_o=0. One more wrong attempt afterwards -> fail_cnt_o=1, no alarm.
6. Enter lockout, then rst=0 at the 5th alarm cycle -> alarm_o=0 and fail_cnt_o=0 next cycle. An immediate attempt_i=match_i=1 after release -> unlock_o=1.
